// File: rtl/bambu_putchar_buf_if.sv
// ---------------------------------------------------------------------------
// bambu_putchar_buf_if
// Groups the call handshake, the TX byte stream and the status outputs of
// bambu_putchar_buf.
//   start_port  : call request from the HLS datapath
//   c           : character to write
//   return_port : c on success, all-ones (EOF) when dropped
//   done_port   : one-cycle completion pulse
//   TX_DATA     : byte to the serializer
//   TX_ENABLE   : one-cycle strobe, TX_DATA valid
//   TX_READY    : serializer can accept
//   fifo_level  : buffer occupancy, 0..DEPTH
//   drop_count  : saturating count of dropped characters
// master = caller/serializer side, slave = the buffer itself.
// ---------------------------------------------------------------------------
interface bambu_putchar_buf_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int LW = $clog2(DEPTH + 1);

  logic              start_port;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] return_port;
  logic              done_port;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_ENABLE;
  logic              TX_READY;
  logic [LW-1:0]     fifo_level;
  logic [15:0]       drop_count;

  modport master (
    output start_port, c, TX_READY,
    input  return_port, done_port, TX_DATA, TX_ENABLE, fifo_level, drop_count
  );

  modport slave (
    input  start_port, c, TX_READY,
    output return_port, done_port, TX_DATA, TX_ENABLE, fifo_level, drop_count
  );
endinterface

// File: rtl/bambu_putchar_buf.sv
// ---------------------------------------------------------------------------
// bambu_putchar_buf
// Bambu-callable putchar with an internal circular buffer feeding a
// UART-style byte stream.
//   clock : system clock, rising edge
//   reset : synchronous, active-high; aborts a pending call (no done)
//   bus   : bambu_putchar_buf_if.slave (call handshake, TX stream, status)
// Parameters:
//   DATA_W   : character width (>= 8)
//   DEPTH    : buffer entries (power of 2, >= 2)
//   BLOCKING : 1 = stall the caller while full, 0 = drop and return EOF
// Optional feature: define BAMBU_PUTCHAR_CRLF_EXPAND_EN to emit CR before
// every buffered LF (the CR does not occupy a buffer slot).
// ---------------------------------------------------------------------------
module bambu_putchar_buf #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int BLOCKING = 1
) (
  input  logic               clock,
  input  logic               reset,
  bambu_putchar_buf_if.slave bus
);
  localparam int                PW         = $clog2(DEPTH);
  localparam int                LW         = $clog2(DEPTH + 1);
  localparam logic [LW-1:0]     FULL_LEVEL = LW'(DEPTH);
  localparam logic [DATA_W-1:0] CHAR_EOF   = {DATA_W{1'b1}};
  localparam bit                DROP_MODE  = (BLOCKING == 0);

  typedef enum logic {FE_IDLE, FE_WRITE} fe_state_t;
  typedef enum logic {TX_IDLE, TX_GAP}   tx_state_t;

  // Front end
  fe_state_t         fe_state_q;
  logic [DATA_W-1:0] c_q;
  logic [DATA_W-1:0] return_q;
  logic              done_q;
  logic [15:0]       drop_count_q;

  // Buffer
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q,  level_d;

  // TX side
  tx_state_t         tx_state_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_en_q;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              tx_grant;
  logic              insert_cr;
  logic [DATA_W-1:0] head_data;

  // Full/empty are judged on the registered level, so a same-cycle pop never
  // frees room for a push and a same-cycle push is never visible to the TX side.
  assign full      = (level_q == FULL_LEVEL);
  assign empty     = (level_q == '0);
  assign head_data = mem_q[rd_ptr_q];
  assign push      = (fe_state_q == FE_WRITE) && !full;
  assign tx_grant  = (tx_state_q == TX_IDLE) && !empty && bus.TX_READY;

`ifdef BAMBU_PUTCHAR_CRLF_EXPAND_EN
  localparam logic [DATA_W-1:0] CHAR_LF = DATA_W'(8'h0A);
  localparam logic [DATA_W-1:0] CHAR_CR = DATA_W'(8'h0D);
  logic lf_pending_q;
  // First grant on an LF head emits CR and leaves the LF in place.
  assign insert_cr = tx_grant && (head_data == CHAR_LF) && !lf_pending_q;
`else
  assign insert_cr = 1'b0;
`endif

  assign pop = tx_grant && !insert_cr;

  // ---------------- front-end FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      fe_state_q   <= FE_IDLE;
      c_q          <= '0;
      return_q     <= '0;
      done_q       <= 1'b0;
      drop_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (fe_state_q)
        FE_IDLE: begin
          if (bus.start_port) begin
            c_q        <= bus.c;
            fe_state_q <= FE_WRITE;
          end
        end
        default: begin
          if (!full) begin
            done_q     <= 1'b1;
            return_q   <= c_q;
            fe_state_q <= FE_IDLE;
          end else if (DROP_MODE) begin
            done_q     <= 1'b1;
            return_q   <= CHAR_EOF;
            fe_state_q <= FE_IDLE;
            if (drop_count_q != 16'hFFFF) begin
              drop_count_q <= drop_count_q + 16'd1;
            end
          end
          // Blocking and full: hold here until a pop makes room.
        end
      endcase
    end
  end

  // ---------------- storage ----------------
  // Contents need no reset: cleared pointers/level make stale entries unreachable.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= c_q;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q   <= TX_IDLE;
      tx_data_q    <= '0;
      tx_en_q      <= 1'b0;
`ifdef BAMBU_PUTCHAR_CRLF_EXPAND_EN
      lf_pending_q <= 1'b0;
`endif
    end else begin
      tx_en_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_grant) begin
            tx_en_q    <= 1'b1;
            tx_state_q <= TX_GAP;
`ifdef BAMBU_PUTCHAR_CRLF_EXPAND_EN
            tx_data_q    <= insert_cr ? CHAR_CR : head_data;
            lf_pending_q <= insert_cr;
`else
            tx_data_q  <= head_data;
`endif
          end
        end
        // Mandatory one-cycle gap keeps strobes at least 2 cycles apart.
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign bus.return_port = return_q;
  assign bus.done_port   = done_q;
  assign bus.TX_DATA     = tx_data_q;
  assign bus.TX_ENABLE   = tx_en_q;
  assign bus.fifo_level  = level_q;
  assign bus.drop_count  = drop_count_q;

endmodule

// File: tb/tb_bambu_putchar_buf.sv
// Bench for bambu_putchar_buf: one blocking and one dropping instance
// (DEPTH=4) driven by directed and random calls, checked against a
// transaction-level model (accepted/popped counts and an expected TX list).
module tb_bambu_putchar_buf;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bambu_putchar_buf_if #(.DATA_W(DW), .DEPTH(D)) ifb ();
  bambu_putchar_buf_if #(.DATA_W(DW), .DEPTH(D)) ifn ();

  bambu_putchar_buf #(.DATA_W(DW), .DEPTH(D), .BLOCKING(1)) u_blk (
    .clock(clk), .reset(rst), .bus(ifb.slave));
  bambu_putchar_buf #(.DATA_W(DW), .DEPTH(D), .BLOCKING(0)) u_nb (
    .clock(clk), .reset(rst), .bus(ifn.slave));

  // Drive side (index 0 = blocking, 1 = dropping)
  logic          start_s [2];
  logic [DW-1:0] c_s     [2];
  logic          rdy_set [2];
  logic          tog_en  [2];
  logic          tog_val = 1'b0;
  int            tog_cnt = 0;

  assign ifb.start_port = start_s[0];
  assign ifb.c          = c_s[0];
  assign ifb.TX_READY   = tog_en[0] ? tog_val : rdy_set[0];
  assign ifn.start_port = start_s[1];
  assign ifn.c          = c_s[1];
  assign ifn.TX_READY   = tog_en[1] ? tog_val : rdy_set[1];

  // Observe side
  logic [DW-1:0] ret_w  [2];
  logic          done_w [2];
  logic [DW-1:0] txd_w  [2];
  logic          txe_w  [2];
  logic [LW-1:0] lvl_w  [2];
  logic [15:0]   drop_w [2];

  assign ret_w[0]  = ifb.return_port;  assign ret_w[1]  = ifn.return_port;
  assign done_w[0] = ifb.done_port;    assign done_w[1] = ifn.done_port;
  assign txd_w[0]  = ifb.TX_DATA;      assign txd_w[1]  = ifn.TX_DATA;
  assign txe_w[0]  = ifb.TX_ENABLE;    assign txe_w[1]  = ifn.TX_ENABLE;
  assign lvl_w[0]  = ifb.fifo_level;   assign lvl_w[1]  = ifn.fifo_level;
  assign drop_w[0] = ifn.drop_count == 16'hx ? 16'h0 : ifb.drop_count;
  assign drop_w[1] = ifn.drop_count;

  // Model: accepted/popped/dropped counts and the expected TX byte list
  int       acc   [2];
  int       pops  [2];
  int       drops [2];
  logic [7:0] exp_data [2][512];
  bit         exp_pop  [2][512];
  int       exp_wr [2];
  int       exp_rd [2];
  int       last_strobe [2];
  int       cyc = 0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      acc[d] = 0; pops[d] = 0; drops[d] = 0;
      exp_wr[d] = 0; exp_rd[d] = 0; last_strobe[d] = -10;
    end
  endtask

  task automatic push_exp(input int d, input logic [7:0] ch);
`ifdef BAMBU_PUTCHAR_CRLF_EXPAND_EN
    if (ch == 8'h0A) begin
      exp_data[d][exp_wr[d]] = 8'h0D;
      exp_pop[d][exp_wr[d]]  = 1'b0;
      exp_wr[d]++;
    end
`endif
    exp_data[d][exp_wr[d]] = ch;
    exp_pop[d][exp_wr[d]]  = 1'b1;
    exp_wr[d]++;
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tog_cnt == 2) begin
      tog_val <= ~tog_val;
      tog_cnt <= 0;
    end else begin
      tog_cnt <= tog_cnt + 1;
    end
  end

  // TX monitor and continuous level/drop checks
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (txe_w[d]) begin
          if (exp_rd[d] == exp_wr[d]) begin
            check("tx_unexpected_strobe", 32'(exp_rd[d]), 32'(exp_wr[d] + 1));
          end else begin
            check("tx_data", 32'(txd_w[d]), 32'(exp_data[d][exp_rd[d]]));
            if (exp_pop[d][exp_rd[d]]) pops[d]++;
            exp_rd[d]++;
          end
          check("tx_gap_ok", 32'(cyc - last_strobe[d] >= 2), 32'd1);
          $display("TX dut%0d data=%02h cycle=%0d", d, txd_w[d], cyc);
          last_strobe[d] = cyc;
        end
        check("fifo_level", 32'(lvl_w[d]), 32'(acc[d] - pops[d]));
        check("drop_count", 32'(drop_w[d]), 32'(drops[d]));
      end
    end
  end

  // One call: start at the current (posedge+1) slot, then follow the
  // model's full/not-full verdict cycle by cycle until completion.
  task automatic call(input int d, input logic [7:0] ch, input int release_at);
    bit got = 1'b0;
    bit full;
    logic [7:0] er = 8'h00;
    start_s[d] = 1'b1;
    c_s[d]     = ch;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    c_s[d]     = 8'($urandom);
    check("done_early", 32'(done_w[d]), 32'd0);
    for (int k = 0; k < 300 && !got; k++) begin
      @(posedge clk); #1;
      if (k == release_at) rdy_set[d] = 1'b1;
      full = ((acc[d] - pops[d]) == D);
      check("done", 32'(done_w[d]), 32'((d == 1) ? 1'b1 : !full));
      if (done_w[d]) begin
        got = 1'b1;
        er  = full ? 8'hFF : ch;
        check("return", 32'(ret_w[d]), 32'(er));
        if (!full) begin
          push_exp(d, ch);
          acc[d]++;
        end else begin
          drops[d]++;
        end
      end
    end
    check("call_completed", 32'(got), 32'd1);
    $display("CALL dut%0d c=%02h ret=%02h", d, ch, ret_w[d]);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done_w[d]), 32'd0);
    check("return_hold", 32'(ret_w[d]), 32'(er));
  endtask

  task automatic drain();
    bit empty = 1'b0;
    tog_en[0] = 1'b0; tog_en[1] = 1'b0;
    rdy_set[0] = 1'b1; rdy_set[1] = 1'b1;
    for (int k = 0; k < 400 && !empty; k++) begin
      @(posedge clk); #1;
      empty = (exp_rd[0] == exp_wr[0]) && (exp_rd[1] == exp_wr[1]);
    end
    check("drain_completed", 32'(empty), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("drained_level0", 32'(lvl_w[0]), 32'd0);
    check("drained_level1", 32'(lvl_w[1]), 32'd0);
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      check("rst_return", 32'(ret_w[d]), 32'd0);
      check("rst_done",   32'(done_w[d]), 32'd0);
      check("rst_txdata", 32'(txd_w[d]), 32'd0);
      check("rst_txen",   32'(txe_w[d]), 32'd0);
      check("rst_level",  32'(lvl_w[d]), 32'd0);
      check("rst_drop",   32'(drop_w[d]), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; c_s[d] = '0; rdy_set[d] = 1'b1; tog_en[d] = 1'b0;
    end
    clear_model();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // Single call with TX_READY high
    call(0, 8'h41, -1);
    drain();

    // Blocking: 5 calls into a stalled serializer; the 5th waits for a pop
    rdy_set[0] = 1'b0;
    for (int i = 0; i < 4; i++) call(0, 8'(8'h10 + i), -1);
    check("blk_full_level", 32'(lvl_w[0]), 32'd4);
    call(0, 8'h14, 3);
    drain();

    // Dropping: 6 calls, the last two return EOF
    rdy_set[1] = 1'b0;
    for (int i = 0; i < 6; i++) call(1, 8'(8'h61 + i), -1);
    check("nb_drop_count", 32'(drop_w[1]), 32'd2);
    check("nb_level", 32'(lvl_w[1]), 32'd4);
    drain();

    // Wrap-around with TX_READY toggling every 3 cycles
    tog_en[0] = 1'b1;
    for (int i = 0; i < 10; i++) call(0, 8'(8'h30 + i), -1);
    drain();

    // Random traffic on both instances
    for (int i = 0; i < 40; i++) begin
      int d;
      logic [7:0] ch;
      d  = int'($urandom_range(0, 1));
      ch = ($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom);
      rdy_set[d] = 1'($urandom_range(0, 1));
      call(d, ch, 4);
    end
    drain();

    // LF handling (CR inserted only when the expansion is built in)
    call(0, 8'h48, -1);
    call(0, 8'h0A, -1);
    drain();

    // Reset while a blocked call is waiting in the write state
    rdy_set[0] = 1'b0;
    for (int i = 0; i < 4; i++) call(0, 8'(8'hA0 + i), -1);
    start_s[0] = 1'b1; c_s[0] = 8'hEE;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("blocked_no_done", 32'(done_w[0]), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs();
    clear_model();
    rst = 1'b0;
    rdy_set[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("aborted_no_done", 32'(done_w[0]), 32'd0);
    end
    call(0, 8'h55, -1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
